// File: rtl/c1_pkg.sv
// Shared constants and state encoding for the C1 window generator.
//   C1_*      : default frame geometry, kernel size, pixel width, read latency
//   c1_state_e: controller states
package c1_pkg;

  localparam int unsigned C1_IMG_W  = 32;
  localparam int unsigned C1_IMG_H  = 32;
  localparam int unsigned C1_K      = 5;
  localparam int unsigned C1_DW     = 16;
  localparam int unsigned C1_RD_LAT = 1;

  localparam int unsigned C1_OW = C1_IMG_W - C1_K + 1;
  localparam int unsigned C1_OH = C1_IMG_H - C1_K + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } c1_state_e;

endpackage

// File: rtl/c1_window_gen_shreg.sv
// KxK sliding-window shift register. Each capture shifts every row one
// column toward c=0 and loads the incoming column at c=K-1.
//   clk     : clock
//   i_clr   : synchronous clear of the whole window
//   i_cap   : capture enable for i_col
//   i_col   : one column, row r in bits [DW*r +: DW]
//   o_win   : window, pixel (r,c) in bits [DW*(r*K+c) +: DW]
module c1_window_shreg #(
  parameter int unsigned K  = 5,
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_cap,
  input  logic [DW*K-1:0]   i_col,
  output logic [DW*K*K-1:0] o_win
);

  logic [DW*K*K-1:0] r_win;

  // Shift left in column index; new column lands in the last column.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_win <= '0;
    end else if (i_cap) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          r_win[DW*(r*K+c) +: DW] <= r_win[DW*(r*K+c+1) +: DW];
        end
        r_win[DW*(r*K+K-1) +: DW] <= i_col[DW*r +: DW];
      end
    end
  end

  assign o_win = r_win;

endmodule

// File: rtl/c1_window_gen.sv
// Read-side controller for the C1 source buffer. Sweeps K parallel buffer
// ports across one frame, one kernel row per port, and assembles the
// returned columns into raster-ordered KxK windows for the PE array.
//   clk, rst    : clock, synchronous active-high reset
//   start       : frame loaded, begin a pass (ignored while busy)
//   busy / done : pass in progress / one-cycle end-of-pass pulse
//   rd_addr_5P  : K read addresses, port p in [32p +: 32]
//   rd_data_5P  : K read data words, port p in [DW*p +: DW]
//   win_valid   : win_data holds a complete window at (win_x, win_y)
module c1_window_gen
  import c1_pkg::*;
#(
  parameter int unsigned IMG_W  = C1_IMG_W,
  parameter int unsigned IMG_H  = C1_IMG_H,
  parameter int unsigned K      = C1_K,
  parameter int unsigned DW     = C1_DW,
  parameter int unsigned RD_LAT = C1_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [32*K-1:0]   rd_addr_5P,
  input  logic [DW*K-1:0]   rd_data_5P,
  output logic              win_valid,
  output logic [DW*K*K-1:0] win_data,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y
);

  localparam int unsigned OW  = IMG_W - K + 1;
  localparam int unsigned OH  = IMG_H - K + 1;
  localparam int unsigned XW  = $clog2(IMG_W + 1);
  localparam int unsigned YW  = $clog2(IMG_H + 1);
  localparam int unsigned CW  = $clog2(IMG_W + 1);
  localparam int unsigned DRW = $clog2(RD_LAT + 1);

  c1_state_e         r_state, w_state_nxt;
  logic [XW-1:0]     r_x, w_x_nxt;
  logic [YW-1:0]     r_oy, w_oy_nxt;
  logic [DRW-1:0]    r_drain, w_drain_nxt;
  logic              w_row_start;
  logic              w_issue;
  logic              w_cap;
  logic [RD_LAT-1:0] r_pipe;
  logic [CW-1:0]     r_col;
  logic              r_busy, r_done, r_win_valid;
  logic [7:0]        r_win_x, r_win_y;
  logic [31:0]       r_addr [K];
  logic [31:0]       w_addr_nxt [K];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, sweep position and row-start strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_oy_nxt    = r_oy;
    w_drain_nxt = r_drain;
    w_row_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SWEEP;
          w_x_nxt     = '0;
          w_oy_nxt    = '0;
          w_row_start = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (r_x == XW'(IMG_W - 1)) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_x_nxt = r_x + XW'(1);
        end
      end
      ST_DRAIN: begin
        // Hold until the last column of the row has returned and been captured.
        if (r_drain == DRW'(RD_LAT)) begin
          if (r_oy < YW'(OH - 1)) begin
            w_state_nxt = ST_SWEEP;
            w_oy_nxt    = r_oy + YW'(1);
            w_x_nxt     = '0;
            w_row_start = 1'b1;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end else begin
          w_drain_nxt = r_drain + DRW'(1);
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Addresses for the column being presented next cycle.
  always_comb begin
    for (int p = 0; p < int'(K); p++) begin
      w_addr_nxt[p] = 32'((32'(w_oy_nxt) + 32'(p)) * 32'(IMG_W) + 32'(w_x_nxt));
    end
  end

  // A column is issued every SWEEP cycle and returns RD_LAT cycles later.
  assign w_issue = (r_state == ST_SWEEP);
  assign w_cap   = r_pipe[RD_LAT-1];

  // Counters, read addresses and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_oy        <= '0;
      r_drain     <= '0;
      r_pipe      <= '0;
      r_col       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_x     <= '0;
      r_win_y     <= '0;
      for (int p = 0; p < int'(K); p++) r_addr[p] <= '0;
    end else begin
      r_x     <= w_x_nxt;
      r_oy    <= w_oy_nxt;
      r_drain <= w_drain_nxt;
      r_pipe  <= RD_LAT'({r_pipe, w_issue});
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FINISH);
      if (w_row_start)  r_col <= '0;
      else if (w_cap)   r_col <= r_col + CW'(1);
      // Window is complete once K columns of this row have been captured.
      r_win_valid <= w_cap && (r_col >= CW'(K - 1));
      if (w_cap && (r_col >= CW'(K - 1))) begin
        r_win_x <= 8'(r_col - CW'(K - 1));
        r_win_y <= 8'(r_oy);
      end
      if (w_state_nxt == ST_SWEEP) begin
        for (int p = 0; p < int'(K); p++) r_addr[p] <= w_addr_nxt[p];
      end
    end
  end

  c1_window_shreg #(
    .K  (K),
    .DW (DW)
  ) u_shreg (
    .clk   (clk),
    .i_clr (rst | w_row_start),
    .i_cap (w_cap),
    .i_col (rd_data_5P),
    .o_win (win_data)
  );

  for (genvar gp = 0; gp < int'(K); gp++) begin : g_addr
    assign rd_addr_5P[32*gp +: 32] = r_addr[gp];
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign win_valid = r_win_valid;
  assign win_x     = r_win_x;
  assign win_y     = r_win_y;

endmodule

// File: tb/tb_c1_window_gen.sv
// Bench for c1_window_gen: default instance (32x32, K=5, RD_LAT=1) and a
// small instance (8x6, K=3, RD_LAT=2), each fed by a behavioural buffer.
module tb_c1_window_gen;

  localparam int W = 32, H = 32, K = 5, DW = 16, OW = 28, OH = 28;
  localparam int SW = 8, SH = 6, SK = 3, SOW = 6, SOH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic                rst, start;
  logic                busy, done, win_valid;
  logic [32*K-1:0]     rd_addr;
  logic [DW*K-1:0]     rd_data;
  logic [DW*K*K-1:0]   win_data;
  logic [7:0]          win_x, win_y;

  c1_window_gen dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr_5P(rd_addr), .rd_data_5P(rd_data), .win_valid(win_valid),
    .win_data(win_data), .win_x(win_x), .win_y(win_y)
  );

  // Small instance
  logic                s_rst, s_start;
  logic                s_busy, s_done, s_win_valid;
  logic [32*SK-1:0]    s_rd_addr;
  logic [DW*SK-1:0]    s_rd_data, s_d1;
  logic [DW*SK*SK-1:0] s_win_data;
  logic [7:0]          s_win_x, s_win_y;

  c1_window_gen #(.IMG_W(8), .IMG_H(6), .K(3), .DW(16), .RD_LAT(2)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_addr_5P(s_rd_addr), .rd_data_5P(s_rd_data), .win_valid(s_win_valid),
    .win_data(s_win_data), .win_x(s_win_x), .win_y(s_win_y)
  );

  // Frame buffers and read-latency models
  logic [15:0] mem  [W*H];
  logic [15:0] smem [SW*SH];

  always @(posedge clk) begin
    for (int p = 0; p < K; p++) rd_data[DW*p +: DW] <= mem[10'(rd_addr[32*p +: 32])];
    for (int p = 0; p < SK; p++) s_d1[DW*p +: DW] <= smem[6'(s_rd_addr[32*p +: 32])];
    s_rd_data <= s_d1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*K*K-1:0] ref_win(input int ox, input int oy);
    logic [DW*K*K-1:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[DW*(r*K+c) +: DW] = mem[(oy+r)*W + ox + c];
    return w;
  endfunction

  function automatic logic [DW*SK*SK-1:0] ref_swin(input int ox, input int oy);
    logic [DW*SK*SK-1:0] w;
    for (int r = 0; r < SK; r++)
      for (int c = 0; c < SK; c++)
        w[DW*(r*SK+c) +: DW] = smem[(oy+r)*SW + ox + c];
    return w;
  endfunction

  // Window monitor, default instance: raster order, contents, no gaps in a row
  int win_cnt, exp_ox, exp_oy, last_cyc, first_cyc;
  logic [DW*K*K-1:0] first_win, last_win;
  always @(negedge clk) begin
    if (win_valid) begin
      if (win_cnt == 0) begin first_cyc = cyc; first_win = win_data; end
      chk("win_xy", 512'({win_y, win_x}), 512'({8'(exp_oy), 8'(exp_ox)}));
      chk("win_data", 512'(win_data), 512'(ref_win(exp_ox, exp_oy)));
      if (exp_ox > 0) chk("row_gap", 512'(cyc), 512'(last_cyc + 1));
      last_cyc = cyc;
      last_win = win_data;
      win_cnt++;
      if (exp_ox == OW-1) begin exp_ox = 0; exp_oy++; end
      else exp_ox++;
    end
  end

  // Window monitor, small instance
  int s_cnt, s_ox, s_oy, s_first_cyc;
  logic [DW*SK*SK-1:0] s_last_win;
  always @(negedge clk) begin
    if (s_win_valid) begin
      if (s_cnt == 0) s_first_cyc = cyc;
      chk("s_win_xy", 512'({s_win_y, s_win_x}), 512'({8'(s_oy), 8'(s_ox)}));
      chk("s_win_data", 512'(s_win_data), 512'(ref_swin(s_ox, s_oy)));
      s_last_win = s_win_data;
      s_cnt++;
      if (s_ox == SOW-1) begin s_ox = 0; s_oy++; end
      else s_ox++;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < W*H; i++) mem[i] = 16'($urandom);
  endtask

  // Called at a negedge; start is high for exactly one cycle (t0).
  task automatic start_frame(output int t0);
    win_cnt = 0; exp_ox = 0; exp_oy = 0;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs to done (bounded), optionally re-pulsing start at t0+repulse.
  // Returns at the negedge of the cycle after done.
  task automatic wait_done(input string tag, input int t0, input int repulse);
    int  n = 0, busy_low = 0, done_cyc = -1;
    bit  seen = 0;
    while (!seen && n < 2000) begin
      if (!busy) busy_low++;
      if (done) begin
        seen = 1;
        done_cyc = cyc;
      end else begin
        start = (repulse != 0 && cyc == t0 + repulse);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 512'(seen), 512'(1));
    chk({tag, "_done_cyc"}, 512'(done_cyc - t0), 512'(953));
    chk({tag, "_busy"}, 512'(busy_low), 512'(0));
    chk({tag, "_windows"}, 512'(win_cnt), 512'(OW*OH));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 512'(done), 512'(0));
    chk({tag, "_idle"}, 512'(busy), 512'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_done"}, 512'(done), 512'(0));
    chk({tag, "_valid"}, 512'(win_valid), 512'(0));
    chk({tag, "_addr"}, 512'(rd_addr), 512'(0));
    chk({tag, "_data"}, 512'(win_data), 512'(0));
    chk({tag, "_xy"}, 512'({win_y, win_x}), 512'(0));
  endtask

  initial begin
    int t0, n, seen, dcyc, vcnt;
    rst = 1'b1; start = 1'b0; s_rst = 1'b1; s_start = 1'b0;
    win_cnt = 0; exp_ox = 0; exp_oy = 0; last_cyc = 0; first_cyc = 0;
    s_cnt = 0; s_ox = 0; s_oy = 0; s_first_cyc = 0;
    for (int i = 0; i < W*H; i++) mem[i] = 16'(i);
    for (int i = 0; i < SW*SH; i++) smem[i] = 16'(i);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);

    // Frame 1: identity pixels
    start_frame(t0);
    chk("addr_p0", 512'(rd_addr[0 +: 32]), 512'(0));
    chk("addr_p3", 512'(rd_addr[96 +: 32]), 512'(96));
    chk("addr_p4", 512'(rd_addr[128 +: 32]), 512'(128));
    chk("busy_t1", 512'(busy), 512'(1));
    wait_done("f1", t0, 0);
    chk("first_win_cyc", 512'(first_cyc - t0), 512'(7));
    for (int c = 0; c < K; c++) begin
      chk("first_r0", 512'(first_win[DW*c +: DW]), 512'(c));
      chk("first_r4", 512'(first_win[DW*(4*K+c) +: DW]), 512'(128 + c));
    end
    chk("last_r4c4", 512'(last_win[DW*24 +: DW]), 512'(1023));

    // Frame 2: random pixels, reset in cycle 300 of the pass
    fill_random();
    start_frame(t0);
    while (cyc < t0 + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midreset");
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done || win_valid) vcnt++;
    end
    chk("midreset_stays_idle", 512'(vcnt), 512'(0));

    // Frame 3: full frame after reset
    start_frame(t0);
    wait_done("f3", t0, 0);

    // Frame 4: start re-pulsed mid-sweep, then frame 5 started the cycle after done
    fill_random();
    start_frame(t0);
    wait_done("f4", t0, 50);
    fill_random();
    start_frame(t0);
    wait_done("f5", t0, 0);

    // Small instance: 8x6, K=3, RD_LAT=2
    s_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    s_start = 1'b0;
    n = 0; seen = 0; dcyc = -1;
    while (!seen && n < 200) begin
      if (s_done) begin seen = 1; dcyc = cyc; end
      else begin @(negedge clk); n++; end
    end
    chk("s_done_seen", 512'(seen), 512'(1));
    chk("s_done_cyc", 512'(dcyc - t0), 512'(45));
    chk("s_windows", 512'(s_cnt), 512'(SOW*SOH));
    chk("s_first_cyc", 512'(s_first_cyc - t0), 512'(6));
    chk("s_last_r2c2", 512'(s_last_win[DW*8 +: DW]), 512'(47));
    @(negedge clk);
    chk("s_done_pulse", 512'(s_done), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
